// File: rtl/c3lib_ckmux4_sel_seq.sv
//------------------------------------------------------------------------------
// c3lib_ckmux4_sel_seq
//
// Purpose:
//   Drives the functional select pins {s1,s0} of the 4-to-1 glitch-free
//   clock mux. A new select is only applied while the downstream clock gate
//   is closed:
//
//     accept -> gate off (OFF_CYC cycles, old select)
//            -> switch select, settle (SETTLE_CYC cycles, gate still off)
//            -> gate on, done pulse (1 cycle)
//            -> idle
//
//   A request for the select that is already applied completes at once:
//   done pulses on the next cycle and nothing else moves.
//   The block runs on a free-running reference clock that is independent of
//   the muxed clocks.
//
// Parameters:
//   OFF_CYC     cycles the gate is held closed on the old select (>= 1)
//   SETTLE_CYC  cycles the gate is held closed on the new select (>= 1)
//   RST_SEL     select value driven from reset
//
// Ports:
//   clk         free-running reference clock
//   rst         asynchronous reset, active-high
//   req_sel     requested mux select {s1,s0}
//   req_vld     request valid (hold with req_sel until accepted)
//   req_rdy     sequencer can accept a request (idle)
//   s0, s1      mux select bits, registered
//   ck_gate_en  downstream clock gate enable, registered, 1 = clock passes
//   busy        switch sequence in progress (gate-off and settle phases)
//   done        one-cycle pulse when a request completes
//   cur_sel     currently applied select, equal to {s1,s0}
//------------------------------------------------------------------------------
module c3lib_ckmux4_sel_seq #(
    parameter int         OFF_CYC    = 4,
    parameter int         SETTLE_CYC = 8,
    parameter logic [1:0] RST_SEL    = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_sel,
    input  logic       req_vld,
    output logic       req_rdy,
    output logic       s0,
    output logic       s1,
    output logic       ck_gate_en,
    output logic       busy,
    output logic       done,
    output logic [1:0] cur_sel
);

    // Counter must hold the larger of the two load values (N-1); sizing on
    // max+1 leaves headroom and keeps the width >= 1 for the 1-cycle case.
    localparam int MAX_CYC = (OFF_CYC > SETTLE_CYC) ? OFF_CYC : SETTLE_CYC;
    localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] OFF_LOAD    = CW'(OFF_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

`ifndef SYNTHESIS
    // Zero-length phases would let the select move with the gate open.
    if (OFF_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_param
        $error("c3lib_ckmux4_sel_seq: OFF_CYC and SETTLE_CYC must be >= 1");
    end
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFF    = 2'd1,
        ST_SWITCH = 2'd2,
        ST_ON     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q,   sel_d;
    logic [1:0]      pend_q,  pend_d;
    logic            gate_q,  gate_d;
    logic            done_q,  done_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    //--------------------------------------------------------------------------
    // State register. Reset snaps the select back to RST_SEL and reopens the
    // gate immediately, without waiting for a clock edge.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= RST_SEL;
            pend_q  <= RST_SEL;
            gate_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic. done_d defaults to 0 so the pulse lasts exactly one
    // cycle; every other register holds unless a transition updates it.
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        gate_d  = gate_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // req_rdy is 1 throughout IDLE, so req_vld alone accepts.
                if (req_vld) begin
                    pend_d = req_sel;
                    if (req_sel == sel_q) begin
                        // Nothing to switch: complete without touching the gate.
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_OFF;
                        gate_d  = 1'b0;
                        cnt_d   = OFF_LOAD;
                    end
                end
            end

            ST_OFF: begin
                // Gate is already closed here; the select may now move.
                if (cnt_q == '0) begin
                    state_d = ST_SWITCH;
                    sel_d   = pend_q;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_SWITCH: begin
                // Let the mux settle on the new clock before reopening.
                if (cnt_q == '0) begin
                    state_d = ST_ON;
                    gate_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_ON: begin
                // One cycle with req_rdy low keeps back-to-back requests
                // separated by at least one idle cycle.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign req_rdy    = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_OFF) || (state_q == ST_SWITCH);
    assign done       = done_q;
    assign ck_gate_en = gate_q;
    assign cur_sel    = sel_q;
    assign s0         = sel_q[0];
    assign s1         = sel_q[1];

`ifndef SYNTHESIS
    // An unknown select captured at accept would propagate straight to the mux.
    a_req_sel_known : assert property (
        @(posedge clk) disable iff (rst)
        (req_vld && req_rdy) |-> !$isunknown(req_sel)
    ) else $error("c3lib_ckmux4_sel_seq: X/Z on req_sel at accept");
`endif

endmodule

// File: tb/tb_c3lib_ckmux4_sel_seq.sv
module tb_c3lib_ckmux4_sel_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Main DUT: OFF_CYC = 4, SETTLE_CYC = 8
    logic [1:0] req_sel = 2'b00;
    logic       req_vld = 1'b0;
    logic       req_rdy, s0, s1, ck_gate_en, busy, done;
    logic [1:0] cur_sel;

    // Fast DUT for the random run: OFF_CYC = 1, SETTLE_CYC = 1
    logic [1:0] req_sel_r = 2'b00;
    logic       req_vld_r = 1'b0;
    logic       req_rdy_r, s0_r, s1_r, ck_gate_en_r, busy_r, done_r;
    logic [1:0] cur_sel_r;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    c3lib_ckmux4_sel_seq #(.OFF_CYC(4), .SETTLE_CYC(8), .RST_SEL(2'b00)) dut (
        .clk(clk), .rst(rst), .req_sel(req_sel), .req_vld(req_vld),
        .req_rdy(req_rdy), .s0(s0), .s1(s1), .ck_gate_en(ck_gate_en),
        .busy(busy), .done(done), .cur_sel(cur_sel)
    );

    c3lib_ckmux4_sel_seq #(.OFF_CYC(1), .SETTLE_CYC(1), .RST_SEL(2'b00)) dut_r (
        .clk(clk), .rst(rst), .req_sel(req_sel_r), .req_vld(req_vld_r),
        .req_rdy(req_rdy_r), .s0(s0_r), .s1(s1_r), .ck_gate_en(ck_gate_en_r),
        .busy(busy_r), .done(done_r), .cur_sel(cur_sel_r)
    );

    // {req_rdy, busy, done, ck_gate_en, s1, s0}
    function automatic logic [5:0] status();
        return {req_rdy, busy, done, ck_gate_en, s1, s0};
    endfunction

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [5:0] exp_st;
        logic [1:0] prev_sel_r;
        int         accepted;
        int         done_cnt;
        int         violations;
        logic       acc_pending;

        //----------------------------------------------------------------------
        // Reset release, idle for 20 cycles
        //----------------------------------------------------------------------
        repeat (3) step();
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            chk($sformatf("idle_c%0d", c), status(), 6'b100100);
        end
        chk("idle_cur_sel", {4'b0, cur_sel}, 6'b000000);
        $display("idle after reset: sel=%b gate=%b", cur_sel, ck_gate_en);

        //----------------------------------------------------------------------
        // Same-select request (00 while cur_sel = 00)
        //----------------------------------------------------------------------
        req_sel = 2'b00;
        req_vld = 1'b1;
        step();                                 // cycle 1
        req_vld = 1'b0;
        chk("same_c1", status(), 6'b101100);
        step();                                 // cycle 2
        chk("same_c2", status(), 6'b100100);
        $display("same-select request 00: done pulse, gate held open");

        //----------------------------------------------------------------------
        // Reset in the middle of a 00 -> 01 sequence
        //----------------------------------------------------------------------
        req_sel = 2'b01;
        req_vld = 1'b1;
        step();                                 // cycle 1
        req_vld = 1'b0;
        chk("rstseq_c1", status(), 6'b010000);
        repeat (4) step();                      // cycle 5
        chk("rstseq_c5", status(), 6'b010001);
        step();                                 // cycle 6
        rst = 1'b1;
        #1;
        chk("rstseq_async", status(), 6'b100100);
        step();
        chk("rstseq_hold1", status(), 6'b100100);
        step();
        rst = 1'b0;
        chk("rstseq_hold2", status(), 6'b100100);
        step();
        chk("rstseq_after", status(), 6'b100100);
        $display("reset mid-sequence 00->01: select back to %b, gate=%b", cur_sel, ck_gate_en);

        //----------------------------------------------------------------------
        // Full sequence 00 -> 10
        //----------------------------------------------------------------------
        req_sel = 2'b10;
        req_vld = 1'b1;
        step();                                 // cycle 1
        req_vld = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c <= 4)       exp_st = 6'b010000;
            else if (c <= 12) exp_st = 6'b010010;
            else if (c == 13) exp_st = 6'b001110;
            else              exp_st = 6'b100110;
            chk($sformatf("seq10_c%0d", c), status(), exp_st);
            if (c != 14) step();
        end
        chk("seq10_cur_sel", {4'b0, cur_sel}, 6'b000010);
        $display("sequence 00->10 complete: sel=%b", cur_sel);

        //----------------------------------------------------------------------
        // 10 -> 01, with a request for 11 presented on cycle 3 and held
        //----------------------------------------------------------------------
        req_sel = 2'b01;
        req_vld = 1'b1;
        step();                                 // cycle 1
        req_vld = 1'b0;
        step();                                 // cycle 2
        step();                                 // cycle 3
        req_sel = 2'b11;
        req_vld = 1'b1;
        for (int c = 3; c <= 14; c++) begin
            if (c <= 4)       exp_st = 6'b010010;
            else if (c <= 12) exp_st = 6'b010001;
            else if (c == 13) exp_st = 6'b001101;
            else              exp_st = 6'b100101;
            chk($sformatf("b2b_c%0d", c), status(), exp_st);
            if (c != 14) step();
        end
        // Accepted at the edge ending cycle 14; cycles 15..27 are the second run.
        for (int c = 15; c <= 28; c++) begin
            step();
            if (c == 15) req_vld = 1'b0;
            if (c <= 18)      exp_st = 6'b010001;
            else if (c <= 26) exp_st = 6'b010011;
            else if (c == 27) exp_st = 6'b001111;
            else              exp_st = 6'b100111;
            chk($sformatf("b2b_c%0d", c), status(), exp_st);
        end
        chk("b2b_cur_sel", {4'b0, cur_sel}, 6'b000011);
        $display("back-to-back 10->01->11 complete: sel=%b", cur_sel);

        //----------------------------------------------------------------------
        // Random requests on the fast instance
        //----------------------------------------------------------------------
        accepted    = 0;
        done_cnt    = 0;
        violations  = 0;
        acc_pending = 1'b0;
        @(negedge clk);
        prev_sel_r = cur_sel_r;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            if (acc_pending) begin
                req_vld_r   = 1'b0;
                acc_pending = 1'b0;
            end
            if (!req_vld_r && $urandom_range(0, 2) == 0) begin
                req_sel_r = 2'($urandom_range(0, 3));
                req_vld_r = 1'b1;
            end
            @(negedge clk);
            if (done_r) done_cnt++;
            if (cur_sel_r != prev_sel_r && ck_gate_en_r) violations++;
            if (cur_sel_r != {s1_r, s0_r}) violations++;
            if (busy_r && ck_gate_en_r) violations++;
            prev_sel_r = cur_sel_r;
            if (req_vld_r && req_rdy_r) begin
                accepted++;
                acc_pending = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        req_vld_r = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_r) done_cnt++;
        end
        n_assert++;
        assert (violations === 0) else begin
            n_fail++;
            $error("FAIL rnd_invariant observed=%0d violations expected=0", violations);
        end
        n_assert++;
        assert (done_cnt === accepted) else begin
            n_fail++;
            $error("FAIL rnd_done_count observed=%0d expected=%0d", done_cnt, accepted);
        end
        $display("random run: %0d requests accepted, %0d done pulses", accepted, done_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
